// File: rtl/apb_regbank_pkg.sv
// Shared definitions for the APB register bank slave:
// register offsets, CTRL field layout, FSM encoding and decode selects.
package apb_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_CTRL   = 3'd1,
    SEL_STATUS = 3'd2,
    SEL_IRQCLR = 3'd3,
    SEL_SCR    = 3'd4
  } sel_e;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_IRQCLR = 8'h08;
  localparam logic [7:0] OFF_SCR0   = 8'h0C;
  localparam logic [7:0] OFF_LAST   = 8'h1C;

  localparam int NUM_SCR        = 5;
  localparam int CTRL_IRQEN_BIT = 0;
  localparam int CTRL_WS_LSB    = 1;
  localparam int CTRL_WS_W      = 3;
  localparam int STAT_PEND_BIT  = 16;

endpackage

// File: rtl/apb_regbank_if.sv
// APB bus bundle between a master and the register bank slave.
// Signal names follow the bus-level port names of the block.
interface apb_regbank_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import apb_regbank_pkg::*;

  logic          apb_psel;
  logic          apb_penable;
  logic          apb_pwrite;
  logic [AW-1:0] apb_paddr;
  logic [DW-1:0] apb_wdata;
  logic          apb_pready;
  logic [DW-1:0] apb_prdata;
  logic          apb_pslverr;

  modport master (
    output apb_psel, apb_penable, apb_pwrite,
    output apb_paddr, apb_wdata,
    input  apb_pready, apb_prdata, apb_pslverr
  );

  modport slave (
    input  apb_psel, apb_penable, apb_pwrite,
    input  apb_paddr, apb_wdata,
    output apb_pready, apb_prdata, apb_pslverr
  );

endinterface

// File: rtl/apb_regbank_decode.sv
// Combinational offset decode: register select, scratch index
// and the slave-error condition for the captured access.
module apb_regbank_decode
  import apb_regbank_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] offset_i,
  input  logic          write_i,
  output sel_e          sel_o,
  output logic [2:0]    scr_idx_o,
  output logic          err_o
);

  logic in_range;
  logic aligned;

  assign in_range = (offset_i <= AW'(OFF_LAST));
  assign aligned  = (offset_i[1:0] == 2'b00);

  always_comb begin
    sel_o     = SEL_NONE;
    scr_idx_o = 3'd0;
    err_o     = 1'b0;
    if (!in_range || !aligned) begin
      err_o = 1'b1;
    end else begin
      unique case (offset_i[4:2])
        3'd0: sel_o = SEL_CTRL;
        3'd1: begin
          sel_o = SEL_STATUS;
          err_o = write_i;
        end
        3'd2: begin
          sel_o = SEL_IRQCLR;
          err_o = !write_i;
        end
        default: begin
          sel_o     = SEL_SCR;
          scr_idx_o = offset_i[4:2] - 3'd3;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave with CTRL/STATUS/IRQCLR/SCRATCH registers, programmable
// wait states, a write counter and a wrap interrupt.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WCNT_WIDTH = 16
) (
  input  logic         apb_pclk,
  input  logic         apb_prst,
  apb_regbank_if.slave bus,
  output logic         irq
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;

  state_e                 state_q, state_d;
  logic [CTRL_WS_W-1:0]   ws_cnt_q, ws_cnt_d;
  logic [AW-1:0]          off_q;
  logic                   wr_q;
  logic [DW-1:0]          wdata_q;
  logic                   irqen_q;
  logic [CTRL_WS_W-1:0]   ws_q;
  logic [DW-1:0]          scr_q [NUM_SCR];
  logic [WCNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic                   pend_q, pend_d;

  sel_e       sel;
  logic [2:0] scr_idx;
  logic       err;
  logic       pready;
  logic       commit;
  logic       wr_ok;
  logic       wrap;
  logic [DW-1:0] rdata;

  apb_regbank_decode #(.AW(AW)) u_dec (
    .offset_i  (off_q),
    .write_i   (wr_q),
    .sel_o     (sel),
    .scr_idx_o (scr_idx),
    .err_o     (err)
  );

  always_comb begin
    state_d  = state_q;
    ws_cnt_d = ws_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.apb_psel && !bus.apb_penable) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        ws_cnt_d = ws_q;
      end
      ST_ACCESS: begin
        if (!bus.apb_psel || pready) state_d = ST_IDLE;
        else ws_cnt_d = ws_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      state_q  <= ST_IDLE;
      ws_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ws_cnt_q <= ws_cnt_d;
    end
  end

  // Bus fields are frozen here; later changes during ACCESS are ignored.
  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      off_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state_q == ST_SETUP) begin
      off_q   <= bus.apb_paddr - BASE_ADDR;
      wr_q    <= bus.apb_pwrite;
      wdata_q <= bus.apb_wdata;
    end
  end

  assign pready = (state_q == ST_ACCESS) && (ws_cnt_q == '0);
  assign commit = pready && bus.apb_psel && bus.apb_penable;
  assign wr_ok  = commit && wr_q && !err;
  assign wrap   = wr_ok && (&wcnt_q);

  always_comb begin
    wcnt_d = wr_ok ? wcnt_q + 1'b1 : wcnt_q;
    pend_d = pend_q;
    if (wr_ok && sel == SEL_IRQCLR && wdata_q[0]) pend_d = 1'b0;
    if (wrap) pend_d = 1'b1;
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      wcnt_q  <= '0;
      pend_q  <= 1'b0;
      irqen_q <= 1'b0;
      ws_q    <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      pend_q <= pend_d;
      if (wr_ok && sel == SEL_CTRL) begin
        irqen_q <= wdata_q[CTRL_IRQEN_BIT];
        ws_q    <= wdata_q[CTRL_WS_LSB +: CTRL_WS_W];
      end
    end
  end

  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      for (int i = 0; i < NUM_SCR; i++) scr_q[i] <= '0;
    end else if (wr_ok && sel == SEL_SCR) begin
      for (int i = 0; i < NUM_SCR; i++) begin
        if (32'(scr_idx) == i) scr_q[i] <= wdata_q;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      SEL_CTRL:   rdata = {28'd0, ws_q, irqen_q};
      SEL_STATUS: rdata = {15'd0, pend_q, 16'(wcnt_q)};
      SEL_SCR: begin
        for (int i = 0; i < NUM_SCR; i++) begin
          if (32'(scr_idx) == i) rdata = scr_q[i];
        end
      end
      default:    rdata = '0;
    endcase
  end

  assign bus.apb_pready  = pready;
  assign bus.apb_pslverr = pready && err;
  assign bus.apb_prdata  = (state_q == ST_ACCESS) ? rdata : '0;
  assign irq             = pend_q && irqen_q;

endmodule
